// File: rtl/lap_tracker_pkg.sv
// Shared types and constants for the lap tracker: quadrant encoding, race FSM states,
// lap-time width and the progress-counter floor.
package lap_pkg;

    localparam int unsigned LAP_TIME_W = 16;
    localparam int NET_SEG_MIN = -4;
    localparam logic [LAP_TIME_W-1:0] LAP_TIME_INIT = 16'hFFFF;

    // Encoding order matches forward travel, so (q - cur) mod 4 is the step direction.
    typedef enum logic [1:0] {
        Q_TL = 2'd0,
        Q_TR = 2'd1,
        Q_BR = 2'd2,
        Q_BL = 2'd3
    } quadrant_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RACING   = 2'd1,
        S_FINISHED = 2'd2
    } race_state_t;

endpackage

// File: rtl/lap_tracker_quadrant.sv
// Combinational classifier mapping a track position onto one of four quadrant checkpoints.
module track_quadrant
    import lap_pkg::*;
#(
    parameter int unsigned MID_X = 1024,
    parameter int unsigned MID_Y = 1024
) (
    input  logic [10:0] i_x,
    input  logic [10:0] i_y,
    output quadrant_t   o_quad
);

    localparam logic [10:0] MX = 11'(MID_X);
    localparam logic [10:0] MY = 11'(MID_Y);

    logic w_xr;
    logic w_yb;

    assign w_xr = (i_x >= MX);
    assign w_yb = (i_y >= MY);

    always_comb begin
        o_quad = Q_TL;
        case ({w_yb, w_xr})
            2'b00:   o_quad = Q_TL;
            2'b01:   o_quad = Q_TR;
            2'b11:   o_quad = Q_BR;
            default: o_quad = Q_BL;
        endcase
    end

endmodule

// File: rtl/lap_tracker.sv
// Tracks kart progress through four quadrant checkpoints per frame; produces lap count,
// win/loss flags, wrong-way indication and frame-based lap timing.
module lap_tracker
    import lap_pkg::*;
#(
    parameter int unsigned MID_X       = 1024,
    parameter int unsigned MID_Y       = 1024,
    parameter int unsigned LAPS_TO_WIN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic                  race_start,
    input  logic                  restart,
    input  logic                  opp_finished,
    input  logic [10:0]           player_x,
    input  logic [10:0]           player_y,
    output logic [2:0]            laps,
    output logic                  lap_pulse,
    output logic                  wrong_way,
    output logic [1:0]            cur_quadrant,
    output logic                  race_won,
    output logic                  race_lost,
    output logic                  finished,
    output logic [LAP_TIME_W-1:0] lap_frames,
    output logic [LAP_TIME_W-1:0] last_lap_frames,
    output logic [LAP_TIME_W-1:0] best_lap_frames
);

    localparam logic [2:0]        LAPS_WIN  = 3'(LAPS_TO_WIN);
    localparam logic signed [3:0] SEG_MAX   = 4'sd3;
    localparam logic signed [3:0] SEG_FLOOR = 4'(NET_SEG_MIN);

    race_state_t r_state;
    race_state_t w_state_nxt;
    quadrant_t   w_q;
    quadrant_t   r_cur_q;

    logic signed [3:0]     r_net_seg;
    logic [2:0]            r_laps;
    logic                  r_lap_pulse;
    logic                  r_wrong_way;
    logic                  r_won;
    logic                  r_lost;
    logic [LAP_TIME_W-1:0] r_lap_frames;
    logic [LAP_TIME_W-1:0] r_last;
    logic [LAP_TIME_W-1:0] r_best;

    logic [1:0]            w_d;
    logic                  w_fwd;
    logic                  w_bwd;
    logic                  w_lap_done;
    logic                  w_win;
    logic [2:0]            w_laps_inc;
    logic [LAP_TIME_W-1:0] w_frames_inc;

    track_quadrant #(
        .MID_X(MID_X),
        .MID_Y(MID_Y)
    ) u_quad (
        .i_x    (player_x),
        .i_y    (player_y),
        .o_quad (w_q)
    );

    assign w_d          = w_q - r_cur_q;
    assign w_fwd        = (r_state == S_RACING) && frame_tick && (w_d == 2'd1);
    assign w_bwd        = (r_state == S_RACING) && frame_tick && (w_d == 2'd3);
    assign w_lap_done   = w_fwd && (r_net_seg == SEG_MAX);
    assign w_laps_inc   = r_laps + 3'd1;
    assign w_win        = w_lap_done && (w_laps_inc == LAPS_WIN);
    assign w_frames_inc = (r_lap_frames == '1) ? r_lap_frames : r_lap_frames + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (restart) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An own win on the completing tick outranks a coincident opponent finish.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (race_start) w_state_nxt = S_RACING;
            S_RACING:   if (w_win || opp_finished) w_state_nxt = S_FINISHED;
            S_FINISHED: w_state_nxt = S_FINISHED;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        finished        = (r_state == S_FINISHED);
        laps            = r_laps;
        lap_pulse       = r_lap_pulse;
        wrong_way       = r_wrong_way;
        cur_quadrant    = r_cur_q;
        race_won        = r_won;
        race_lost       = r_lost;
        lap_frames      = r_lap_frames;
        last_lap_frames = r_last;
        best_lap_frames = r_best;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_q      <= Q_TL;
            r_net_seg    <= '0;
            r_laps       <= '0;
            r_lap_pulse  <= 1'b0;
            r_wrong_way  <= 1'b0;
            r_won        <= 1'b0;
            r_lost       <= 1'b0;
            r_lap_frames <= '0;
            r_last       <= '0;
            r_best       <= LAP_TIME_INIT;
        end else if (restart) begin
            r_cur_q      <= Q_TL;
            r_net_seg    <= '0;
            r_laps       <= '0;
            r_lap_pulse  <= 1'b0;
            r_wrong_way  <= 1'b0;
            r_won        <= 1'b0;
            r_lost       <= 1'b0;
            r_lap_frames <= '0;
            r_last       <= '0;
            r_best       <= LAP_TIME_INIT;
        end else begin
            r_lap_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (race_start) begin
                        r_cur_q      <= w_q;
                        r_net_seg    <= '0;
                        r_lap_frames <= '0;
                        r_laps       <= '0;
                    end
                end
                S_RACING: begin
                    if (frame_tick) r_lap_frames <= w_frames_inc;
                    if (w_fwd) begin
                        r_cur_q     <= w_q;
                        r_wrong_way <= 1'b0;
                        if (w_lap_done) begin
                            r_laps       <= w_laps_inc;
                            r_net_seg    <= '0;
                            r_lap_pulse  <= 1'b1;
                            r_last       <= w_frames_inc;
                            r_best       <= (w_frames_inc < r_best) ? w_frames_inc : r_best;
                            r_lap_frames <= '0;
                        end else begin
                            r_net_seg <= r_net_seg + 4'sd1;
                        end
                    end else if (w_bwd) begin
                        r_cur_q     <= w_q;
                        r_wrong_way <= 1'b1;
                        if (r_net_seg != SEG_FLOOR) r_net_seg <= r_net_seg - 4'sd1;
                    end
                    if (w_win)             r_won  <= 1'b1;
                    else if (opp_finished) r_lost <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
